shifter_16b_arb_ctrl: RTL and testbench
=======================================

// Module: shifter_16b_arb_ctrl
// PURPOSE
//  Shares one shifter_16b_top datapath between two requesters: round-robin arbitration, operand capture, result register.
//  Valid/ready on both request ports and on the single tagged response port; one operation in flight.
//  Sits between the register-file/ALU issue logic and the barrel shifter.
// PARAMETERS
//  DATA_W   16  operand/result width; fixed at 16 to match shifter_16b_top
//  SHIFT_W  4   shift-amount width, log2(DATA_W)
// PORTS
//  clk         in   1        system clock; all state changes on rising edge
//  rst_n       in   1        synchronous, active-low reset
//  req0_valid  in   1        requester 0 has an operation
//  req0_ready  out  1        requester 0 operation accepted this cycle
//  req0_data   in   DATA_W   operand
//  req0_shift  in   SHIFT_W  shift amount, 0..15
//  req0_dir    in   1        0 = left, 1 = right; vacated bits zero-filled
//  req0_rot    in   1        1 = rotate instead of shift (only with SHIFT_ARB_ROTATE_EN)
//  req1_*      --   --       same set as req0_* for requester 1
//  rsp_valid   out  1        result available
//  rsp_ready   in   1        consumer takes result
//  rsp_data    out  DATA_W   result
//  rsp_id      out  1        index of the requester that owns rsp_data
//  busy        out  1        state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, last_grant=1; any in-flight op is dropped with no response.
//  States: IDLE -> EXEC -> [EXEC2] -> RESP -> IDLE.
//  IDLE: grant = only valid requester; if both valid, grant != last_grant. reqN_ready = (state==IDLE) && grant==N.
//   Handshake at edge N latches data/shift/dir/id into op regs, updates last_grant, state=EXEC.
//  EXEC: shifter driven from op regs; output registered at edge N+1 -> RESP, rsp_valid=1 from cycle N+2 (2-cycle latency).
//  RESP: rsp_valid/rsp_data/rsp_id held stable until rsp_valid&&rsp_ready; then rsp_valid=0, state=IDLE.
//   No new request is accepted in the cycle the response retires; throughput is 1 op per 3 cycles minimum.
//  Requesters must hold valid and fields stable until ready; ready depends combinationally on valid, never the reverse.
//  shift=0 returns the operand unchanged; shift=15 left of 0x0001 = 0x8000.
//  Requester not granted sees ready=0 and keeps waiting; no starvation (strict alternation under contention).
// CONFIGURATION
//  SHIFT_ARB_ROTATE_EN defined: reqN_rot ports exist. Rotate with shift s != 0 makes two passes through the shifter:
//   EXEC = shift x by s in dir, result -> acc; EXEC2 = shift original x by (16-s) in opposite dir; rsp_data = acc | pass2.
//   Rotate latency 3 cycles; rotate with s=0 is a single pass (2 cycles), returns x.
//  SHIFT_ARB_ROTATE_EN undefined: no rot ports, no EXEC2 state, no acc register; all ops single-pass.
// STRUCTURE
//  Package shifter_ctrl_pkg: state encoding (IDLE, EXEC, EXEC2, RESP), DIR_LEFT=0/DIR_RIGHT=1, DATA_W/SHIFT_W constants.
//  One sub-module: shifter_16b_top instance (shared datapath), inputs from op regs and pass-select mux.
//  Arbiter, FSM, op/acc/result registers inline in this module.
// TESTING
//  1. rst_n=0 two cycles with req0_valid=1 -> rsp_valid=0, busy=0, req0_ready=0 during reset; req0_ready=1 first cycle after.
//  2. req0: data=0x00F0 shift=4 dir=0, rsp_ready=1 -> rsp_data=0x0F00, rsp_id=0, rsp_valid at handshake+2.
//  3. both valid from reset: req0 0x8001 shift=1 dir=1, req1 0x0001 shift=15 dir=0 -> rsp id0 0x4000 then id1 0x8000; repeat -> id0 first again.
//  4. rsp_ready=0 ten cycles after result -> rsp_data/rsp_id stable, rsp_valid=1, both req ready=0 throughout.
//  5. ROTATE_EN: req0 0x8001 rot=1 shift=1 dir=0 -> 0x0003 at +3; rot=1 shift=0 -> 0x8001 at +2; shift=4 dir=1 on 0x1234 -> 0x4123.
//  6. rst_n=0 one cycle while state=EXEC -> next cycle busy=0, rsp_valid=0; no response for the dropped op ever appears.

Source files
------------

// File: rtl/shifter_ctrl_pkg.sv
// Shared constants and FSM state encoding for the shifter arbitration controller.
package shifter_ctrl_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SHIFT_W = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/shifter_16b_top.sv
// Combinational logarithmic barrel shifter; vacated bits are zero-filled.
module shifter_16b_top #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SHIFT_W = 4
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               dir,
  output logic [DATA_W-1:0]  result
);
  import shifter_ctrl_pkg::*;

  always_comb begin
    result = data;
    for (int unsigned i = 0; i < SHIFT_W; i++) begin
      if (shift[i]) begin
        if (dir == DIR_RIGHT) result = result >> (1 << i);
        else                  result = result << (1 << i);
      end
    end
  end

endmodule

// File: rtl/shifter_16b_arb_ctrl.sv
// Two-requester round-robin front end for one shared shifter_16b_top, one op in flight.
// Optional rotate support (two shifter passes) is enabled by defining SHIFT_ARB_ROTATE_EN.
module shifter_16b_arb_ctrl #(
  parameter int unsigned DATA_W  = shifter_ctrl_pkg::DATA_W,
  parameter int unsigned SHIFT_W = shifter_ctrl_pkg::SHIFT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHIFT_W-1:0] req0_shift,
  input  logic               req0_dir,
`ifdef SHIFT_ARB_ROTATE_EN
  input  logic               req0_rot,
  input  logic               req1_rot,
`endif
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHIFT_W-1:0] req1_shift,
  input  logic               req1_dir,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_id,
  output logic               busy
);
  import shifter_ctrl_pkg::*;

  state_t state, next;

  logic               last_grant;
  logic               grant;
  logic               any_valid;
  logic               accept;
  logic [DATA_W-1:0]  op_data;
  logic [SHIFT_W-1:0] op_shift;
  logic               op_dir;
  logic               op_id;
  logic [SHIFT_W-1:0] sh_shift;
  logic               sh_dir;
  logic [DATA_W-1:0]  sh_out;
`ifdef SHIFT_ARB_ROTATE_EN
  logic               op_rot;
  logic [DATA_W-1:0]  acc;
`endif

  // Under contention the requester that did not win last time is granted.
  assign any_valid = req0_valid | req1_valid;
  assign grant     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign busy      = (state != IDLE);

  always_comb begin
    sh_shift = op_shift;
    sh_dir   = op_dir;
`ifdef SHIFT_ARB_ROTATE_EN
    // Second rotate pass: (DATA_W - s) wraps to -s in SHIFT_W bits.
    if (state == EXEC2) begin
      sh_shift = '0 - op_shift;
      sh_dir   = ~op_dir;
    end
`endif
  end

  shifter_16b_top #(
    .DATA_W (DATA_W),
    .SHIFT_W(SHIFT_W)
  ) u_shifter (
    .data  (op_data),
    .shift (sh_shift),
    .dir   (sh_dir),
    .result(sh_out)
  );

  always_comb begin
    next       = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && any_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          next       = EXEC;
        end
      end
      EXEC: begin
`ifdef SHIFT_ARB_ROTATE_EN
        if (op_rot && (op_shift != '0)) next = EXEC2;
        else                            next = RESP;
`else
        next = RESP;
`endif
      end
      EXEC2: next = RESP;
      RESP:  if (rsp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      op_data    <= '0;
      op_shift   <= '0;
      op_dir     <= DIR_LEFT;
      op_id      <= 1'b0;
`ifdef SHIFT_ARB_ROTATE_EN
      op_rot     <= 1'b0;
      acc        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_data    <= grant ? req1_data  : req0_data;
            op_shift   <= grant ? req1_shift : req0_shift;
            op_dir     <= grant ? req1_dir   : req0_dir;
            op_id      <= grant;
            last_grant <= grant;
`ifdef SHIFT_ARB_ROTATE_EN
            op_rot     <= grant ? req1_rot   : req0_rot;
`endif
          end
        end
        EXEC: begin
`ifdef SHIFT_ARB_ROTATE_EN
          if (next == EXEC2) begin
            acc <= sh_out;
          end else begin
            rsp_data  <= sh_out;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
          end
`else
          rsp_data  <= sh_out;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
`endif
        end
        EXEC2: begin
`ifdef SHIFT_ARB_ROTATE_EN
          rsp_data  <= acc | sh_out;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
`endif
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_16b_arb_ctrl.sv
// Directed self-checking bench for shifter_16b_arb_ctrl (rotate cases need SHIFT_ARB_ROTATE_EN).
module tb_shifter_16b_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_dir;
  logic [15:0] req0_data;
  logic [3:0]  req0_shift;
  logic        req1_valid, req1_ready, req1_dir;
  logic [15:0] req1_data;
  logic [3:0]  req1_shift;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] rsp_data;
`ifdef SHIFT_ARB_ROTATE_EN
  logic        req0_rot, req1_rot;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  shifter_16b_arb_ctrl #(.DATA_W(16), .SHIFT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_data (req0_data),
    .req0_shift(req0_shift),
    .req0_dir  (req0_dir),
`ifdef SHIFT_ARB_ROTATE_EN
    .req0_rot  (req0_rot),
    .req1_rot  (req1_rot),
`endif
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_data (req1_data),
    .req1_shift(req1_shift),
    .req1_dir  (req1_dir),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects requester g to be granted now, then the result exactly lat cycles after the handshake.
  task automatic op_expect(input string tag, input int g, input int lat, input logic [15:0] exp_d);
    #1;
    check({tag, ".rdy0"}, 16'(req0_ready), 16'(g == 0));
    check({tag, ".rdy1"}, 16'(req1_ready), 16'(g == 1));
    tick();
    check({tag, ".busy"}, 16'(busy), 16'd1);
    for (int i = 1; i < lat; i++) begin
      check({tag, ".early"}, 16'(rsp_valid), 16'd0);
      tick();
    end
    check({tag, ".valid"}, 16'(rsp_valid), 16'd1);
    check({tag, ".data"}, rsp_data, exp_d);
    check({tag, ".id"}, 16'(rsp_id), 16'(g));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n      = 1'b0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h00F0; req0_shift = 4'd4; req0_dir = 1'b0;
    req1_valid = 1'b0; req1_data = 16'h0000; req1_shift = 4'd0; req1_dir = 1'b0;
`ifdef SHIFT_ARB_ROTATE_EN
    req0_rot = 1'b0; req1_rot = 1'b0;
`endif

    // Reset held two cycles with req0 asking
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst.rdy0", 16'(req0_ready), 16'd0);
      check("rst.busy", 16'(busy), 16'd0);
      check("rst.valid", 16'(rsp_valid), 16'd0);
      check("rst.data", rsp_data, 16'h0000);
    end
    rst_n = 1'b1;

    // Single left shift, 2-cycle latency
    op_expect("t2", 0, 2, 16'h0F00);
    req0_valid = 1'b0;
    tick();
    check("t2.idle", 16'(busy), 16'd0);
    check("t2.retire", 16'(rsp_valid), 16'd0);

    // Contention from reset: strict alternation starting with requester 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h8001; req0_shift = 4'd1;  req0_dir = 1'b1;
    req1_valid = 1'b1; req1_data = 16'h0001; req1_shift = 4'd15; req1_dir = 1'b0;
    op_expect("t3a", 0, 2, 16'h4000);
    tick();
    op_expect("t3b", 1, 2, 16'h8000);
    tick();
    op_expect("t3c", 0, 2, 16'h4000);

    // Back-pressure: response held stable for ten cycles, nothing accepted
    rsp_ready = 1'b0;
    req1_data = 16'h1234; req1_shift = 4'd8; req1_dir = 1'b1;
    #1 rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    op_expect("t4", 1, 2, 16'h0012);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4.hold.valid", 16'(rsp_valid), 16'd1);
      check("t4.hold.data", rsp_data, 16'h0012);
      check("t4.hold.id", 16'(rsp_id), 16'd1);
      check("t4.hold.rdy0", 16'(req0_ready), 16'd0);
      check("t4.hold.rdy1", 16'(req1_ready), 16'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("t4.retire", 16'(rsp_valid), 16'd0);

    // Boundaries: shift 0 passes through, right shift by 15
    req0_data = 16'hA5C3; req0_shift = 4'd0;  req0_dir = 1'b1;
    req1_data = 16'hFFFF; req1_shift = 4'd15; req1_dir = 1'b1;
    op_expect("s0", 0, 2, 16'hA5C3);
    tick();
    op_expect("s15r", 1, 2, 16'h0001);
    req1_valid = 1'b0;
    tick();

`ifdef SHIFT_ARB_ROTATE_EN
    // Rotates: two passes unless amount is zero
    req0_rot = 1'b1; req0_data = 16'h8001; req0_shift = 4'd1; req0_dir = 1'b0;
    op_expect("rotl1", 0, 3, 16'h0003);
    tick();
    req0_shift = 4'd0;
    op_expect("rot0", 0, 2, 16'h8001);
    tick();
    req0_data = 16'h1234; req0_shift = 4'd4; req0_dir = 1'b1;
    op_expect("rotr4", 0, 3, 16'h4123);
    tick();
    req0_rot = 1'b0;
`endif

    // Reset while an op is executing drops it silently
    req0_valid = 1'b1; req0_data = 16'h0001; req0_shift = 4'd1; req0_dir = 1'b0;
    #1 check("t6.rdy0", 16'(req0_ready), 16'd1);
    tick();
    check("t6.busy", 16'(busy), 16'd1);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6.busy0", 16'(busy), 16'd0);
    check("t6.valid0", 16'(rsp_valid), 16'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6.noresp", 16'(rsp_valid), 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
